// File: rtl/cpu_press_gen_pkg.sv
// Purpose: shared tug-of-war types and constants (FSM states, LFSR width/seed/taps).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tow_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2,
    HALT    = 2'd3
  } cpu_state_t;

  localparam int LFSR_W_DEF = 10;
  localparam logic [LFSR_W_DEF-1:0] LFSR_SEED = '0;

  // XNOR feedback taps; all-ones is the lock-up state and is never reached from seed 0
  localparam int LFSR_TAP_A = 9;
  localparam int LFSR_TAP_B = 6;

endpackage

// File: rtl/cpu_press_gen_if.sv
// Purpose: bundles the computer-opponent tick/control inputs and press/debug outputs.
// Latency: n/a (wiring only). Optional press_count under CPU_PRESS_STATS_EN.
// Backpressure: none; press is a fire-and-forget pulse.
interface cpu_press_gen_if #(
  parameter int LFSR_W = 10
);
  logic              enable;
  logic [LFSR_W-1:0] difficulty;
  logic              gameOver;
  logic              restartGame;
  logic              press;
  logic [LFSR_W-1:0] lfsr_q;
`ifdef CPU_PRESS_STATS_EN
  logic [15:0]       press_count;

  modport master (output enable, difficulty, gameOver, restartGame,
                  input  press, lfsr_q, press_count);
  modport slave  (input  enable, difficulty, gameOver, restartGame,
                  output press, lfsr_q, press_count);
`else
  modport master (output enable, difficulty, gameOver, restartGame,
                  input  press, lfsr_q);
  modport slave  (input  enable, difficulty, gameOver, restartGame,
                  output press, lfsr_q);
`endif
endinterface

// File: rtl/cpu_press_gen_lfsr10.sv
// Purpose: XNOR-form Fibonacci LFSR used as the game's pseudo-random source.
// Latency: new value one Clock after an enable cycle; synchronous active-low Reset to seed.
// Backpressure: none; holds its value whenever enable is low.
module lfsr10
  import tow_pkg::*;
#(
  parameter int W = LFSR_W_DEF
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         enable,
  output logic [W-1:0] q
);

  // shift left, feeding back the XNOR of the two taps
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      q <= W'(LFSR_SEED);
    end else if (enable) begin
      q <= {q[W-2:0], ~(q[LFSR_TAP_A] ^ q[LFSR_TAP_B])};
    end
  end

endmodule

// File: rtl/cpu_press_gen.sv
// Purpose: computer opponent; on each game tick a random draw below difficulty emits one press, then a release holdoff.
// Latency: qualifying tick in cycle n gives press in n+1 only. Optional press_count under CPU_PRESS_STATS_EN.
// Backpressure: none; the light chain consumes press unconditionally.
module cpu_press_gen
  import tow_pkg::*;
#(
  parameter int LFSR_W  = LFSR_W_DEF,
  parameter int HOLDOFF = 2
) (
  input  logic            Clock,
  input  logic            Reset,
  cpu_press_gen_if.slave  bus
);

  localparam int CNT_W = $clog2(HOLDOFF + 1);

  cpu_state_t        state;
  cpu_state_t        state_d;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_en;
  logic              press;

  // LFSR is frozen in HALT, but a restart tick lets it advance again
  assign lfsr_en = bus.enable & ((state != HALT) | bus.restartGame);

  lfsr10 #(.W(LFSR_W)) u_lfsr (
    .Clock  (Clock),
    .Reset  (Reset),
    .enable (lfsr_en),
    .q      (lfsr_q)
  );

  assign bus.lfsr_q = lfsr_q;

  // state and holdoff counter registers
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // next state: restart beats gameOver, gameOver beats normal play
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (bus.restartGame) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (bus.gameOver) begin
      state_d = HALT;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.enable && (bus.difficulty > lfsr_q)) state_d = PRESS;
        end
        PRESS: begin
          state_d = RELEASE;
          cnt_d   = CNT_W'(HOLDOFF);
        end
        RELEASE: begin
          if (bus.enable) begin
            if (cnt == CNT_W'(1)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt - CNT_W'(1);
            end
          end
        end
        HALT: state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // press is a pure decode of the state register, so it is glitch-free
  always_comb begin
    press = (state == PRESS);
  end

  assign bus.press = press;

`ifdef CPU_PRESS_STATS_EN
  logic [15:0] press_count;

  // saturating count of press cycles since reset or the last restart
  always_ff @(posedge Clock) begin
    if (!Reset || bus.restartGame) begin
      press_count <= '0;
    end else if (press && (press_count != 16'hFFFF)) begin
      press_count <= press_count + 16'd1;
    end
  end

  assign bus.press_count = press_count;
`endif

endmodule

// File: tb/tb_cpu_press_gen.sv
// Purpose: directed self-checking bench for cpu_press_gen with a per-cycle expectation queue.
// Latency: each step pushes the expected post-edge outputs, then pops and compares them #1 after the edge.
// Backpressure: n/a.
module tb_cpu_press_gen;

  typedef struct {
    logic        press;
    logic [9:0]  lfsr;
    logic [15:0] cnt;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  int   presses = 0;

  exp_t        sb[$];
  logic [9:0]  m_lfsr = '0;
  logic [15:0] m_cnt = '0;
  logic        prev_press = 1'b0;

  cpu_press_gen_if #(.LFSR_W(10)) ifc ();

  cpu_press_gen #(.LFSR_W(10), .HOLDOFF(2)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (ifc.slave)
  );

  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] lfsr_step(input logic [9:0] x);
    return {x[8:0], ~(x[9] ^ x[6])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one cycle of inputs, queue the expected outputs, compare after the edge
  task automatic step(input logic rst_n, input logic en, input logic go,
                      input logic rs, input logic exp_p, input logic adv);
    exp_t e;
    Reset           = rst_n;
    ifc.enable      = en;
    ifc.gameOver    = go;
    ifc.restartGame = rs;
    if (!rst_n)   m_lfsr = '0;
    else if (adv) m_lfsr = lfsr_step(m_lfsr);
    if (!rst_n || rs)                        m_cnt = '0;
    else if (prev_press && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    prev_press = exp_p;
    e.press = exp_p;
    e.lfsr  = m_lfsr;
    e.cnt   = m_cnt;
    sb.push_back(e);
    @(posedge Clock);
    #1;
    e = sb.pop_front();
    chk("press", 32'(ifc.press), 32'(e.press));
    chk("lfsr_q", 32'(ifc.lfsr_q), 32'(e.lfsr));
`ifdef CPU_PRESS_STATS_EN
    chk("press_count", 32'(ifc.press_count), 32'(e.cnt));
`endif
    if (ifc.press === 1'b1) presses++;
  endtask

  initial begin
    Reset           = 1'b0;
    ifc.enable      = 1'b1;
    ifc.difficulty  = 10'h000;
    ifc.gameOver    = 1'b0;
    ifc.restartGame = 1'b0;

    // reset held two cycles with enable high
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);

    // difficulty 0: LFSR walks its full period twice, no presses
    presses = 0;
    for (int i = 1; i <= 2046; i++) begin
      step(1, 1, 0, 0, 0, 1);
      if (i == 1)    chk("lfsr_t1", 32'(ifc.lfsr_q), 32'h001);
      if (i == 2)    chk("lfsr_t2", 32'(ifc.lfsr_q), 32'h003);
      if (i == 3)    chk("lfsr_t3", 32'(ifc.lfsr_q), 32'h007);
      if (i == 1023) chk("lfsr_period1", 32'(ifc.lfsr_q), 32'h000);
      if (i == 2046) chk("lfsr_period2", 32'(ifc.lfsr_q), 32'h000);
    end
    chk("no_press_d0", 32'(presses), 32'd0);

    // difficulty max, enable tied high: 1,0,0,0 pattern
    ifc.difficulty = 10'h3FF;
    presses = 0;
    for (int k = 0; k < 1000; k++) step(1, 1, 0, 0, (k % 4) == 0, 1);
    chk("press_250", 32'(presses), 32'd250);

    // sparse ticks: PRESS is one cycle, RELEASE holds its count between ticks
    step(1, 1, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);

    // gameOver on the qualifying tick blocks the press, then freezes the LFSR
    step(1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 1, 1);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);

    // restart together with gameOver lands in IDLE; gameOver during PRESS halts
    step(1, 0, 1, 1, 0, 0);
    step(1, 1, 0, 0, 1, 1);
    step(1, 1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);

    // no ticks: no press, LFSR constant
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1);

    // reset during PRESS clears press and LFSR
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1);

`ifdef CPU_PRESS_STATS_EN
    // preload the counter just below full and let it saturate
    force dut.press_count = 16'hFFFE;
    #1;
    release dut.press_count;
    m_cnt = 16'hFFFE;
    for (int j = 0; j < 8; j++) step(1, 1, 0, 0, (j % 4) == 3, 1);
    chk("count_sat", 32'(ifc.press_count), 32'hFFFF);
    step(1, 0, 0, 1, 0, 0);
    chk("count_clr", 32'(ifc.press_count), 32'h0);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
